// File: rtl/canny_hyst_thresh.sv
// Canny double-threshold / hysteresis stage: classifies the centre of a 3x3 magnitude window.
// Optional HYST_EDGE_CNT_EN adds a per-frame edge-pixel counter (edge_cnt, cnt_valid).
module canny_hyst_thresh #(
  parameter int          DW        = 16,
  parameter int          IMG_W     = 640,
  parameter int          IMG_H     = 480,
  parameter int unsigned TH_HI_RST = 500,
  parameter int unsigned TH_LO_RST = 400
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [DW-1:0] th_hi_in,
  input  logic [DW-1:0] th_lo_in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [DW-1:0] p11,
  input  logic [DW-1:0] p12,
  input  logic [DW-1:0] p13,
  input  logic [DW-1:0] p21,
  input  logic [DW-1:0] p22,
  input  logic [DW-1:0] p23,
  input  logic [DW-1:0] p31,
  input  logic [DW-1:0] p32,
  input  logic [DW-1:0] p33,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sof,
  output logic          out_eof,
  output logic          overrun
`ifdef HYST_EDGE_CNT_EN
  ,
  output logic [31:0]   edge_cnt,
  output logic          cnt_valid
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Handshake: a beat moves in on in_valid&in_ready, out on out_valid&out_ready;
  // both stages shift together whenever the output register is empty or being drained.
  logic adv, acc, sof_acc;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign acc      = in_valid && adv;
  assign sof_acc  = acc && in_sof;

  logic [DW-1:0] sh_hi, sh_lo, act_hi, act_lo;
  logic [DW-1:0] cur_hi, cur_lo_raw, cur_lo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_hi  <= DW'(TH_HI_RST);
      sh_lo  <= DW'(TH_LO_RST);
      act_hi <= DW'(TH_HI_RST);
      act_lo <= DW'(TH_LO_RST);
    end else begin
      if (cfg_we) begin
        sh_hi <= th_hi_in;
        sh_lo <= th_lo_in;
      end
      // Copy takes the shadow value present before any same-cycle cfg write.
      if (sof_acc) begin
        act_hi <= sh_hi;
        act_lo <= sh_lo;
      end
    end
  end

  // The sof beat already uses the freshly copied thresholds.
  assign cur_hi     = sof_acc ? sh_hi : act_hi;
  assign cur_lo_raw = sof_acc ? sh_lo : act_lo;
  assign cur_lo     = (cur_lo_raw > cur_hi) ? cur_hi : cur_lo_raw;

  logic [RW-1:0] row, beat_row;
  logic [CW-1:0] col, beat_col;
  logic          done, ovr_beat, last_beat;

  always_comb begin
    beat_row  = in_sof ? '0 : row;
    beat_col  = in_sof ? '0 : col;
    ovr_beat  = !in_sof && done;
    last_beat = !ovr_beat && (beat_row == ROW_LAST) && (beat_col == COL_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row     <= '0;
      col     <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else if (acc) begin
      if (ovr_beat) begin
        overrun <= 1'b1;
      end else if (last_beat) begin
        done <= 1'b1;
        row  <= beat_row;
        col  <= beat_col;
      end else begin
        done <= 1'b0;
        if (beat_col == COL_LAST) begin
          col <= '0;
          row <= beat_row + RW'(1);
        end else begin
          col <= beat_col + CW'(1);
          row <= beat_row;
        end
      end
    end
  end

  logic c_strong, c_weak, c_nbr, c_border;

  always_comb begin
    c_strong = (p22 >= cur_hi);
    c_weak   = (p22 >= cur_lo) && !c_strong;
    c_nbr    = (p11 >= cur_hi) || (p12 >= cur_hi) || (p13 >= cur_hi) ||
               (p21 >= cur_hi) || (p23 >= cur_hi) ||
               (p31 >= cur_hi) || (p32 >= cur_hi) || (p33 >= cur_hi);
    // Overrun beats are folded into the border path so they emerge as zero.
    c_border = (beat_row == '0) || (beat_row == ROW_LAST) ||
               (beat_col == '0) || (beat_col == COL_LAST) || ovr_beat;
  end

  logic          s1_valid, s1_strong, s1_weak, s1_nbr, s1_border, s1_sof, s1_eof;
  logic [DW-1:0] s1_p22;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_strong <= 1'b0;
      s1_weak   <= 1'b0;
      s1_nbr    <= 1'b0;
      s1_border <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eof    <= 1'b0;
      s1_p22    <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_strong <= c_strong;
      s1_weak   <= c_weak;
      s1_nbr    <= c_nbr;
      s1_border <= c_border;
      s1_sof    <= in_valid && in_sof;
      s1_eof    <= in_valid && last_beat;
      s1_p22    <= p22;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      out_sof   <= s1_valid && s1_sof;
      out_eof   <= s1_valid && s1_eof;
      out_data  <= (s1_valid && !s1_border && (s1_strong || (s1_weak && s1_nbr))) ? s1_p22 : '0;
    end
  end

`ifdef HYST_EDGE_CNT_EN
  logic        out_xfer;
  logic [31:0] cnt, cnt_next;

  assign out_xfer = out_valid && out_ready;
  // A sof pixel restarts the count with its own contribution.
  assign cnt_next = (out_sof ? 32'd0 : cnt) + {31'd0, (out_data != '0)};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      edge_cnt  <= '0;
      cnt_valid <= 1'b0;
    end else begin
      cnt_valid <= 1'b0;
      if (out_xfer) begin
        cnt <= cnt_next;
        if (out_eof) begin
          edge_cnt  <= cnt_next;
          cnt_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_canny_hyst_thresh.sv
// Directed bench for canny_hyst_thresh on an 8x6 image with default thresholds 500/400.
// Build with HYST_EDGE_CNT_EN defined to also check the edge counter.
module tb_canny_hyst_thresh;

  localparam int DW = 16;
  localparam int W  = DW + 2;

  logic          clk = 1'b0;
  logic          rst_n, cfg_we, in_valid, in_ready, in_sof;
  logic [DW-1:0] th_hi_in, th_lo_in;
  logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic          out_valid, out_ready, out_sof, out_eof, overrun;
  logic [DW-1:0] out_data;
`ifdef HYST_EDGE_CNT_EN
  logic [31:0]   edge_cnt;
  logic          cnt_valid;
`endif

  canny_hyst_thresh #(.DW(DW), .IMG_W(8), .IMG_H(6), .TH_HI_RST(500), .TH_LO_RST(400)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .th_hi_in(th_hi_in), .th_lo_in(th_lo_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .p11(p11), .p12(p12), .p13(p13), .p21(p21), .p22(p22), .p23(p23),
    .p31(p31), .p32(p32), .p33(p33),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .overrun(overrun)
`ifdef HYST_EDGE_CNT_EN
    , .edge_cnt(edge_cnt), .cnt_valid(cnt_valid)
`endif
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] c;
    logic [DW-1:0] nb;
    logic [DW-1:0] p;
    logic [DW-1:0] exp_d;
  } vec_t;
  vec_t vec[22];

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           ready_mode = 0;
  logic         last_acc;
  int           last_acc_cyc;
  logic         held_v = 1'b0;
  logic [W-1:0] held;
  int           cnt_pulses = 0;
  logic [31:0]  last_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void set_vec(input int i, input int c, input int nb, input int p, input int e);
    vec[i].c     = DW'(c);
    vec[i].nb    = DW'(nb);
    vec[i].p     = DW'(p);
    vec[i].exp_d = DW'(e);
  endfunction

  // One clock: monitor/scoreboard before the edge, then update out_ready after it.
  task automatic tick();
    logic [W-1:0] e;
    int a;
    #1;
    last_acc = 1'b0;
    if (rst_n) begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (held_v) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hold", {14'd0, out_sof, out_eof, out_data}, {14'd0, held});
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", {14'd0, out_sof, out_eof, out_data}, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          a = lat_q.pop_front();
          chk("out_beat", {14'd0, out_sof, out_eof, out_data}, {14'd0, e});
          if (ready_mode == 0) chk("latency", cyc - a, 2);
        end
      end else if (out_valid) begin
        held_v = 1'b1;
        held   = {out_sof, out_eof, out_data};
      end
      last_acc     = in_valid && in_ready;
      last_acc_cyc = cyc;
    end
`ifdef HYST_EDGE_CNT_EN
    if (cnt_valid) begin
      cnt_pulses++;
      last_cnt = edge_cnt;
    end
`endif
    @(posedge clk);
    cyc++;
    #1;
    out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : (ready_mode == 2) ? 1'b0 : 1'b1;
  endtask

  task automatic send_beat(input logic sof, input logic [DW-1:0] c, input logic [DW-1:0] nb,
                           input logic [DW-1:0] p, input logic [DW-1:0] ed, input logic ee);
    logic got;
    got = 1'b0;
    in_valid = 1'b1;
    in_sof = sof;
    p11 = nb; p12 = nb; p13 = p; p21 = nb; p22 = c; p23 = nb; p31 = nb; p32 = nb; p33 = nb;
    for (int t = 0; t < 200 && !got; t++) begin
      tick();
      got = last_acc;
    end
    if (got) begin
      exp_q.push_back({sof, ee, ed});
      lat_q.push_back(last_acc_cyc);
    end else begin
      chk("accept_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic cfg_write(input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    in_valid = 1'b0;
    cfg_we = 1'b1;
    th_hi_in = hi;
    th_lo_in = lo;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 400 && exp_q.size() > 0; t++) tick();
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      lat_q.delete();
    end
    tick();
    tick();
  endtask

  // Frame of 48 beats; table entries go to interior pixels in raster order.
  task automatic send_frame(input int first, input int n, input logic [DW-1:0] fill,
                            input logic [DW-1:0] exp_fill, input int cfg_at, input bit sof_cfg);
    int k, r, cc;
    bit brd;
    logic [DW-1:0] c, nb, p, e;
    k = first;
    for (int b = 0; b < 48; b++) begin
      r = b / 8;
      cc = b % 8;
      brd = (r == 0) || (r == 5) || (cc == 0) || (cc == 7);
      if (!brd && k < first + n) begin
        c = vec[k].c; nb = vec[k].nb; p = vec[k].p; e = vec[k].exp_d;
        k++;
      end else begin
        c = fill; nb = fill; p = fill;
        e = brd ? '0 : exp_fill;
      end
      if (b == cfg_at) cfg_write(16'd300, 16'd200);
      if (b == 0 && sof_cfg) begin
        cfg_we = 1'b1;
        th_hi_in = 16'd300;
        th_lo_in = 16'd700;
      end
      send_beat(b == 0, c, nb, p, e, b == 47);
      cfg_we = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_sof_eof", {30'd0, out_sof, out_eof}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef HYST_EDGE_CNT_EN
    chk("rst_edge_cnt", edge_cnt, 32'd0);
    chk("rst_cnt_valid", {31'd0, cnt_valid}, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    lat_q.delete();
    held_v = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; th_hi_in = '0; th_lo_in = '0;
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    p11 = '0; p12 = '0; p13 = '0; p21 = '0; p22 = '0; p23 = '0; p31 = '0; p32 = '0; p33 = '0;

    // {centre, other neighbours, p13, expected} at thresholds 500/400
    set_vec(0, 450, 100, 520, 450);
    set_vec(1, 450, 100, 499, 0);
    set_vec(2, 399, 100, 520, 0);
    set_vec(3, 500, 100, 100, 500);
    set_vec(4, 400, 100, 500, 400);
    set_vec(5, 499, 499, 499, 0);
    set_vec(6, 65535, 0, 0, 65535);
    set_vec(7, 0, 600, 600, 0);
    set_vec(8, 450, 520, 520, 450);
    set_vec(9, 350, 100, 100, 0);
    // thresholds 300/200
    set_vec(10, 350, 100, 100, 350);
    set_vec(11, 250, 100, 300, 250);
    set_vec(12, 250, 299, 299, 0);
    set_vec(13, 199, 600, 600, 0);
    set_vec(14, 200, 100, 300, 200);
    // hi=300, lo=700 -> weak class empty
    set_vec(15, 299, 600, 600, 0);
    set_vec(16, 300, 0, 0, 300);
    set_vec(17, 650, 100, 310, 650);
    set_vec(18, 299, 0, 0, 0);
    // back to reset thresholds 500/400
    set_vec(19, 450, 100, 520, 450);
    set_vec(20, 350, 100, 600, 0);
    set_vec(21, 420, 100, 500, 420);

    do_reset();

    // flat 600 frame: border zero, interior 600, latency 2
    cnt_pulses = 0;
    send_frame(0, 0, 16'd600, 16'd600, -1, 1'b0);
    drain();
`ifdef HYST_EDGE_CNT_EN
    chk("cnt_pulses_a", cnt_pulses, 1);
    chk("edge_cnt_a", last_cnt, 24);
`endif

    // classification vectors under random backpressure, shadow write mid-frame
    ready_mode = 1;
    send_frame(0, 10, 16'd0, 16'd0, 12, 1'b0);
    drain();
    ready_mode = 0;
    out_ready = 1'b1;

    // new thresholds active; simultaneous cfg write lands in the next frame
    send_frame(10, 5, 16'd0, 16'd0, -1, 1'b1);
    drain();
    send_frame(15, 4, 16'd0, 16'd0, -1, 1'b0);
    drain();

    // beat after eof without sof
    chk("overrun_before", {31'd0, overrun}, 32'd0);
    send_beat(1'b0, 16'd600, 16'd600, 16'd600, 16'd0, 1'b0);
    drain();
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    cnt_pulses = 0;
    send_frame(0, 0, 16'd600, 16'd600, -1, 1'b0);
    drain();
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
`ifdef HYST_EDGE_CNT_EN
    chk("cnt_pulses_b", cnt_pulses, 1);
    chk("edge_cnt_b", last_cnt, 24);
`endif

    // reset with both stages full and output stalled
    ready_mode = 2;
    out_ready = 1'b0;
    send_beat(1'b1, 16'd600, 16'd600, 16'd600, 16'd0, 1'b0);
    send_beat(1'b0, 16'd600, 16'd600, 16'd600, 16'd0, 1'b0);
    #1;
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    do_reset();
    ready_mode = 0;
    out_ready = 1'b1;
    send_frame(19, 3, 16'd0, 16'd0, -1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/canny_hyst_thresh.md
Name: canny_hyst_thresh

Overview:
- Parametrised double-threshold / hysteresis stage of the Canny pipeline. Sits between non-maximum suppression (3x3 window generator output) and the edge-map writer.
- Classifies each centre pixel of a 3x3 gradient-magnitude window as strong, weak-promoted or suppressed.
- Runtime thresholds are double-buffered per frame. Image borders are forced to zero from internal row/column counters.
- Uses a 2-stage valid/ready pipeline with full backpressure.

Parameters:
DW, 16, magnitude/data width in bits
IMG_W, 640, active pixels per line (>=3)
IMG_H, 480, active lines per frame (>=3)
TH_HI_RST, 500, reset value of high threshold shadow/active registers
TH_LO_RST, 400, reset value of low threshold shadow/active registers

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  write th_hi_in/th_lo_in into shadow registers
th_hi_in  in  DW  high threshold (shadow)
th_lo_in  in  DW  low threshold (shadow)
in_valid  in  1  window beat valid
in_ready  out  1  block accepts beat this cycle
in_sof  in  1  first pixel of frame, qualified by in_valid&in_ready
p11..p33  in  DW each  3x3 window, p22 = centre (nine ports)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_data  out  DW  edge value
out_sof  out  1  aligned with first output pixel of frame
out_eof  out  1  aligned with last output pixel (row IMG_H-1, col IMG_W-1)
overrun  out  1  sticky: beat accepted after eof without new sof

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_data=0, out_sof=0, out_eof=0, overrun=0, stage valids=0, row=col=0. Shadow and active thresholds are set to TH_HI_RST/TH_LO_RST.
- Handshake:
  - adv = !out_valid | out_ready; in_ready = adv (combinational).
  - A beat transfers when in_valid&in_ready; an output transfers when out_valid&out_ready.
  - When adv=1, both stages shift, and a stage valid loads 0 on a bubble.
  - out_data/out_sof/out_eof hold stable while out_valid&!out_ready.
- Latency: exactly 2 clk from accepted beat to out_valid when out_ready=1. Throughput is 1 pixel/clk.
- Thresholds:
  - cfg_we writes shadow registers at any time.
  - Active registers copy shadow on an accepted in_sof beat. The copy is used from that same beat onward.
  - If active th_lo > th_hi, the effective low threshold is th_hi (weak class empty).
- Position counters:
  - Update on accepted beats only.
  - An in_sof beat is position (0,0), regardless of the prior count.
  - col wraps IMG_W-1 -> 0 and increments row.
  - After (IMG_H-1, IMG_W-1), the frame is complete. A further non-sof beat sets overrun=1 (sticky until reset), holds row/col at the last position and is output as 0.
- Stage 1 (registered): strong = p22 >= th_hi; weak = p22 >= th_lo & !strong; nbr = OR of (pXY >= th_hi) over the 8 neighbours; border = row==0 | row==IMG_H-1 | col==0 | col==IMG_W-1. p22, sof and eof flags are also registered.
- Stage 2 (registered):
  - out_data = 0 if border.
  - Otherwise out_data = p22 if strong | (weak & nbr).
  - Otherwise out_data = 0.
- Comparisons are unsigned, DW bits, no truncation.
- in_sof with in_valid=0 is ignored. Simultaneous cfg_we and sof copy: the active register takes the pre-write shadow value; the new value applies at the next frame.

Optional Feature:
- Macro HYST_EDGE_CNT_EN.
- Defined:
  - Adds outputs edge_cnt (32 bits) and cnt_valid (1 bit).
  - An internal counter increments per output transfer with out_data != 0 and clears on out_sof transfer (the counter then starts at that pixel's contribution).
  - On out_eof transfer, edge_cnt latches the final count and cnt_valid pulses 1 clk.
  - Reset value of both is 0.
- Undefined: no ports, no logic; all other behaviour is identical.

Test Plan:
- IMG_W=8, IMG_H=6, DW=16, defaults. Stream 48 beats, all p=600 -> interior 24 pixels out_data=600, 24 border pixels out_data=0, out_eof on beat 48, latency 2.
- Interior p22=450, neighbours 100 except p13=520 -> out_data=450; same with p13=499 -> out_data=0; p22=399 -> 0; p22=500 -> 500.
- out_ready toggled 1-0-0-1 pseudo-randomly during frame -> no beat lost or duplicated, out_data stable during stall, in_ready=0 whenever out_valid&!out_ready.
- cfg_we th_hi=300, th_lo=200 mid-frame -> current frame still uses 500/400; next sof frame classifies p22=350 interior as strong; th_lo=700, th_hi=300 -> only >=300 passes.
- Send 49th beat without in_sof -> overrun=1 and out_data=0. Then send sof -> counters restart at (0,0) and overrun stays 1 until rst_n=0.
- Assert rst_n=0 with pipeline full -> next cycle out_valid=0 and thresholds=500/400. With HYST_EDGE_CNT_EN and the first test, edge_cnt=24 and cnt_valid pulses once.
